hazard_fwd_ctrl: RTL and testbench
==================================

# hazard_fwd_ctrl

Pipeline hazard controller for the 5-stage CPU. It tracks destination-register metadata for the instructions in EX, MEM and WB using internal shadow registers, and generates the 2-bit select codes for the two EX-stage operand forwarding muxes. It also produces the load-use stall, the branch flush and the global freeze for multi-cycle data-memory accesses. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and drives their enables and clears.

## Interface
- STALL_CNT_W, 16, width of saturating stall-event counter
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- id_rs_i  in  5  rs field of instruction in ID
- id_rt_i  in  5  rt field of instruction in ID
- id_uses_rt_i  in  1  ID instruction reads rt as a source
- id_rd_i  in  5  resolved destination register of ID instruction
- id_regwrite_i  in  1  ID instruction writes the register file
- id_memread_i  in  1  ID instruction is a load
- id_branch_taken_i  in  1  branch in ID resolved taken
- dmem_busy_i  in  1  data memory not ready this cycle
- fw_a_o  out  2  select for EX operand A mux
- fw_b_o  out  2  select for EX operand B mux
- stall_o  out  1  hold PC and IF/ID; bubble into ID/EX
- flush_o  out  1  clear IF/ID
- freeze_o  out  1  hold all pipeline registers
- stall_cnt_o  out  STALL_CNT_W  count of stall_o cycles, saturating

## Operation
- Each shadow entry holds: rs, rt, rd, regwrite, memread. These are advanced ID→EX→MEM→WB each cycle unless freeze_o is high.
- On stall_o, the EX entry loads a bubble with regwrite=0 and memread=0. MEM and WB advance normally.
- Forwarding select codes: 00 = ID/EX read data, 10 = EX/MEM result, 01 = MEM/WB result. Code 11 is never driven.
- fw_a_o is derived from the EX entry's rs; fw_b_o from its rt.
  - If MEM.regwrite, MEM.rd≠0 and MEM.rd equals the source, the code is 10.
  - Otherwise, if WB.regwrite, WB.rd≠0 and WB.rd equals the source, the code is 01.
  - Otherwise the code is 00.
- EX/MEM takes priority over MEM/WB because it holds the newer value.
- Register $0 is never forwarded.
- Load-use stall: stall_o=1 when EX.memread, EX.rd≠0, and either EX.rd==id_rs_i or (id_uses_rt_i and EX.rd==id_rt_i).
- flush_o = id_branch_taken_i & ~stall_o & ~freeze_o.
  - If a stall and a taken branch coincide, the stall wins. The branch re-evaluates next cycle.
- freeze_o = dmem_busy_i.
  - While frozen, stall_o and flush_o are forced to 0, the shadow registers hold, and the fw codes stay stable.
- stall_cnt_o increments on each cycle with stall_o=1 and saturates at all-ones.
- The register file is write-before-read, so WB never causes an ID-stage hazard.

## Timing
- fw_a_o, fw_b_o, stall_o, flush_o and freeze_o are combinational from the shadow registers and the current-cycle inputs. Zero latency.
- Shadow registers and stall_cnt_o update on the rising edge of clk_i.
- A load-use hazard costs exactly 1 stall cycle with FWD_EN defined. In the following cycle the load sits in WB relative to the consumer, so the consumer's EX cycle sees fw=01.
- Reset, synchronous:
  - all shadow entries are set to regwrite=0, memread=0, fields 0;
  - fw_a_o=fw_b_o=00, stall_o=0, flush_o=0, freeze_o follows dmem_busy_i, stall_cnt_o=0.
- Reset asserted mid-stall or mid-freeze discards the in-flight state. The next cycle starts from the reset state.

## Configuration
- HAZARD_FWD_EN defined: forwarding and load-use detection as described above.
- HAZARD_FWD_EN undefined:
  - fw_a_o=fw_b_o=00 constantly;
  - stall_o=1 whenever an ID source (rs, or rt if used) is nonzero and matches the rd of a regwrite entry in EX or MEM;
  - a back-to-back dependency therefore costs 2 stall cycles, and a dependency one instruction apart costs 1.
  - Freeze and flush behaviour is unchanged.

## Structure
- Shared package hazard_pkg holds:
  - FW_IDEX=2'b00, FW_MEMWB=2'b01, FW_EXMEM=2'b10;
  - REG_ZERO=5'd0;
  - the shadow-entry struct (rs, rt, rd, regwrite, memread) and its BUBBLE constant.
- One sub-module, hz_shadow_stage: a single shadow entry register with hold (freeze) and bubble-load inputs, instantiated three times.

## Test plan
- `add $3,$1,$2` then `sub $4,$3,$5` → in sub's EX cycle, fw_a_o=10 and fw_b_o=00. No stall.
- `add $3,$1,$2`; `nop`; `or $6,$5,$3` → in or's EX cycle, fw_b_o=01.
- `lw $2,0($1)` then `add $4,$2,$2` → stall_o=1 for one cycle and stall_cnt_o goes 0→1. Then, in add's EX cycle, fw_a_o=fw_b_o=01.
- `add $0,$1,$2` then `sub $4,$0,$0` → fw_a_o=fw_b_o=00.
- `add $3`, `add $3`, `sub $4,$3,$3` → fw=10 (newest wins). Separately, taken branch coinciding with a load-use stall → flush_o=0 that cycle and 1 the next.
- dmem_busy_i high for 3 cycles mid-sequence → freeze_o=1, fw codes held, stall_cnt_o unchanged. Separately, with HAZARD_FWD_EN undefined, scenario 1 → stall_o high for 2 cycles and fw always 00.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared definitions for the pipeline hazard controller.
//               Forwarding select encodings, the shadow-entry record kept for
//               each of EX/MEM/WB, and helpers for destination matching.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Operand forwarding mux select encodings (2'b11 is never produced)
  localparam logic [1:0] FW_IDEX  = 2'b00;
  localparam logic [1:0] FW_MEMWB = 2'b01;
  localparam logic [1:0] FW_EXMEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Destination/source metadata of one in-flight instruction
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } shadow_t;

  localparam shadow_t BUBBLE = '{rs: REG_ZERO, rt: REG_ZERO, rd: REG_ZERO,
                                 regwrite: 1'b0, memread: 1'b0};

  // True when entry e will write register src; $0 never counts as a producer
  function automatic logic dest_hit(input shadow_t e, input logic [4:0] src);
    return e.regwrite && (e.rd != REG_ZERO) && (e.rd == src);
  endfunction

  // Select code for one EX operand; the MEM-stage producer is newer, so it
  // is checked first
  function automatic logic [1:0] fw_select(input logic [4:0] src,
                                           input shadow_t    mem,
                                           input shadow_t    wb);
    if (dest_hit(mem, src)) return FW_EXMEM;
    if (dest_hit(wb, src))  return FW_MEMWB;
    return FW_IDEX;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hz_shadow_stage.sv
`default_nettype none
// ============================================================================
// Module      : hz_shadow_stage
// Description : One shadow pipeline entry. Holds while hold_i is high,
//               otherwise loads either a bubble (bubble_i) or d_i.
// Ports       : clk_i, rst_i  - clock, synchronous active-high reset
//               hold_i        - keep current contents (pipeline freeze)
//               bubble_i      - load BUBBLE instead of d_i
//               d_i / q_o     - entry from previous stage / current entry
// Revision    : 1.0 - initial release
// ============================================================================
module hz_shadow_stage
  import hazard_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    hold_i,
  input  logic    bubble_i,
  input  shadow_t d_i,
  output shadow_t q_o
);

  shadow_t entry_q;
  shadow_t entry_d;

  always_comb begin
    entry_d = entry_q;
    if (!hold_i) begin
      entry_d = bubble_i ? BUBBLE : d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q <= BUBBLE;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q_o = entry_q;

endmodule
`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_fwd_ctrl
// Description : Hazard controller for the 5-stage pipeline. Shadows the
//               EX/MEM/WB destination metadata, drives the EX operand
//               forwarding selects, the load-use stall, the branch flush and
//               the data-memory freeze, and counts stall cycles.
// Config      : HAZARD_FWD_EN defined   -> forwarding + load-use stall only
//               HAZARD_FWD_EN undefined -> no forwarding, stall on any RAW
//                                          dependency against EX or MEM
// Ports       : clk_i, rst_i          - clock, synchronous active-high reset
//               id_*_i                - decoded fields of the ID instruction
//               id_branch_taken_i     - ID branch resolved taken
//               dmem_busy_i           - data memory not ready this cycle
//               fw_a_o / fw_b_o       - EX operand A/B forwarding selects
//               stall_o, flush_o      - load-use stall, IF/ID clear
//               freeze_o              - hold all pipeline registers
//               stall_cnt_o           - saturating count of stall cycles
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [4:0]             id_rs_i,
  input  logic [4:0]             id_rt_i,
  input  logic                   id_uses_rt_i,
  input  logic [4:0]             id_rd_i,
  input  logic                   id_regwrite_i,
  input  logic                   id_memread_i,
  input  logic                   id_branch_taken_i,
  input  logic                   dmem_busy_i,
  output logic [1:0]             fw_a_o,
  output logic [1:0]             fw_b_o,
  output logic                   stall_o,
  output logic                   flush_o,
  output logic                   freeze_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  shadow_t id_entry;
  shadow_t ex_q;
  shadow_t mem_q;
  shadow_t wb_q;
  logic    hazard;
  logic [1:0] fw_a_raw;
  logic [1:0] fw_b_raw;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d;

  assign id_entry = '{rs: id_rs_i, rt: id_rt_i, rd: id_rd_i,
                      regwrite: id_regwrite_i, memread: id_memread_i};

  hz_shadow_stage u_ex (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .hold_i   (freeze_o),
    .bubble_i (stall_o),
    .d_i      (id_entry),
    .q_o      (ex_q)
  );

  hz_shadow_stage u_mem (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .hold_i   (freeze_o),
    .bubble_i (1'b0),
    .d_i      (ex_q),
    .q_o      (mem_q)
  );

  hz_shadow_stage u_wb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .hold_i   (freeze_o),
    .bubble_i (1'b0),
    .d_i      (mem_q),
    .q_o      (wb_q)
  );

`ifdef HAZARD_FWD_EN
  // Only a load in EX cannot be forwarded in time for the ID consumer
  assign hazard = ex_q.memread && (ex_q.rd != REG_ZERO) &&
                  ((ex_q.rd == id_rs_i) || (id_uses_rt_i && (ex_q.rd == id_rt_i)));
  assign fw_a_raw = fw_select(ex_q.rs, mem_q, wb_q);
  assign fw_b_raw = fw_select(ex_q.rt, mem_q, wb_q);
`else
  // Without forwarding every producer still in EX or MEM blocks ID; WB is
  // covered by the write-before-read register file
  assign hazard = dest_hit(ex_q, id_rs_i) || dest_hit(mem_q, id_rs_i) ||
                  (id_uses_rt_i && (dest_hit(ex_q, id_rt_i) || dest_hit(mem_q, id_rt_i)));
  assign fw_a_raw = FW_IDEX;
  assign fw_b_raw = FW_IDEX;
`endif

  // Not every shadow field feeds logic in every build
  logic unused_shadow;
  assign unused_shadow = ^{ex_q, mem_q, wb_q};

  assign freeze_o = dmem_busy_i;
  // Reset gating keeps the outputs at their idle values while in-flight
  // state is being discarded
  assign stall_o  = hazard & ~freeze_o & ~rst_i;
  assign flush_o  = id_branch_taken_i & ~stall_o & ~freeze_o & ~rst_i;
  assign fw_a_o   = rst_i ? FW_IDEX : fw_a_raw;
  assign fw_b_o   = rst_i ? FW_IDEX : fw_b_raw;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_fwd_ctrl
// Description : Directed scoreboard bench for hazard_fwd_ctrl. The stimulus
//               process plays the fetch/decode side (holding ID on stall)
//               and queues hand-derived expectations; a monitor compares on
//               the falling edge. A narrow counter exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_ctrl;

  localparam int CW = 3;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       ut;
    logic       rw;
    logic       mr;
  } ins_t;

  typedef struct {
    string      nm;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic       fl;
    logic       fz;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic          id_ut, id_rw, id_mr, br, busy;
  logic [1:0]    fw_a, fw_b;
  logic          stall, flush, freeze;
  logic [CW-1:0] cnt;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] ecnt   = '0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.STALL_CNT_W(CW)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .id_rs_i           (id_rs),
    .id_rt_i           (id_rt),
    .id_uses_rt_i      (id_ut),
    .id_rd_i           (id_rd),
    .id_regwrite_i     (id_rw),
    .id_memread_i      (id_mr),
    .id_branch_taken_i (br),
    .dmem_busy_i       (busy),
    .fw_a_o            (fw_a),
    .fw_b_o            (fw_b),
    .stall_o           (stall),
    .flush_o           (flush),
    .freeze_o          (freeze),
    .stall_cnt_o       (cnt)
  );

  function automatic ins_t R(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return '{rs: rs, rt: rt, rd: rd, ut: 1'b1, rw: 1'b1, mr: 1'b0};
  endfunction

  function automatic ins_t LW(input logic [4:0] rt, input logic [4:0] rs);
    return '{rs: rs, rt: rt, rd: rt, ut: 1'b0, rw: 1'b1, mr: 1'b1};
  endfunction

  function automatic ins_t BEQ(input logic [4:0] rs, input logic [4:0] rt);
    return '{rs: rs, rt: rt, rd: 5'd0, ut: 1'b1, rw: 1'b0, mr: 1'b0};
  endfunction

  function automatic ins_t NOP();
    return '{rs: 5'd0, rt: 5'd0, rd: 5'd0, ut: 1'b0, rw: 1'b0, mr: 1'b0};
  endfunction

  task automatic cmp(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", nm, f, act, exp);
    end
  endtask

  // One cycle: drive ID/control inputs, queue the expected outputs
  task automatic go(input string nm, input ins_t i, input logic b, input logic bz,
                    input logic r, input logic [1:0] efa, input logic [1:0] efb,
                    input logic est, input logic efl);
    exp_t e;
    id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
    id_ut = i.ut; id_rw = i.rw; id_mr = i.mr;
    br = b; busy = bz; rst = r;
    e.nm = nm; e.fa = efa; e.fb = efb; e.st = est; e.fl = efl; e.fz = bz; e.cnt = ecnt;
    sb.push_back(e);
    if (r) ecnt = '0;
    else if (est && (ecnt != '1)) ecnt = ecnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) go("drain", NOP(), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp(e.nm, "fw_a",   32'(fw_a),   32'(e.fa));
      cmp(e.nm, "fw_b",   32'(fw_b),   32'(e.fb));
      cmp(e.nm, "stall",  32'(stall),  32'(e.st));
      cmp(e.nm, "flush",  32'(flush),  32'(e.fl));
      cmp(e.nm, "freeze", 32'(freeze), 32'(e.fz));
      cmp(e.nm, "cnt",    32'(cnt),    32'(e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; busy = 1'b0; br = 1'b0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_ut = 1'b0; id_rw = 1'b0; id_mr = 1'b0;
    @(posedge clk);
    #1;
    // Reset: outputs idle, freeze follows busy, taken branch not flushed
    go("reset", R(5'd3, 5'd1, 5'd2), 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    drain();

`ifdef HAZARD_FWD_EN
    // add $3,$1,$2 ; sub $4,$3,$5
    go("s1_add", R(5'd3, 5'd1, 5'd2), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s1_sub", R(5'd4, 5'd3, 5'd5), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s1_ex",  NOP(),               0, 0, 0, 2'b10, 2'b00, 0, 0);
    drain();
    // add $3,$1,$2 ; nop ; or $6,$5,$3
    go("s2_add", R(5'd3, 5'd1, 5'd2), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s2_nop", NOP(),               0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s2_or",  R(5'd6, 5'd5, 5'd3), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s2_ex",  NOP(),               0, 0, 0, 2'b00, 2'b01, 0, 0);
    drain();
    // lw $2,0($1) ; add $4,$2,$2
    go("s3_lw",   LW(5'd2, 5'd1),      0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s3_stl",  R(5'd4, 5'd2, 5'd2), 0, 0, 0, 2'b00, 2'b00, 1, 0);
    go("s3_hold", R(5'd4, 5'd2, 5'd2), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s3_ex",   NOP(),               0, 0, 0, 2'b01, 2'b01, 0, 0);
    drain();
`else
    go("s1_add",  R(5'd3, 5'd1, 5'd2), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s1_stl1", R(5'd4, 5'd3, 5'd5), 0, 0, 0, 2'b00, 2'b00, 1, 0);
    go("s1_stl2", R(5'd4, 5'd3, 5'd5), 0, 0, 0, 2'b00, 2'b00, 1, 0);
    go("s1_go",   R(5'd4, 5'd3, 5'd5), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s1_ex",   NOP(),               0, 0, 0, 2'b00, 2'b00, 0, 0);
    drain();
    go("s2_add",  R(5'd3, 5'd1, 5'd2), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s2_nop",  NOP(),               0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s2_stl",  R(5'd6, 5'd5, 5'd3), 0, 0, 0, 2'b00, 2'b00, 1, 0);
    go("s2_go",   R(5'd6, 5'd5, 5'd3), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s2_ex",   NOP(),               0, 0, 0, 2'b00, 2'b00, 0, 0);
    drain();
    go("s3_lw",   LW(5'd2, 5'd1),      0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s3_stl1", R(5'd4, 5'd2, 5'd2), 0, 0, 0, 2'b00, 2'b00, 1, 0);
    go("s3_stl2", R(5'd4, 5'd2, 5'd2), 0, 0, 0, 2'b00, 2'b00, 1, 0);
    go("s3_go",   R(5'd4, 5'd2, 5'd2), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s3_ex",   NOP(),               0, 0, 0, 2'b00, 2'b00, 0, 0);
    drain();
`endif

    // add $0,$1,$2 ; sub $4,$0,$0 : $0 never forwarded nor stalled on
    go("s4_add", R(5'd0, 5'd1, 5'd2), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s4_sub", R(5'd4, 5'd0, 5'd0), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s4_ex",  NOP(),               0, 0, 0, 2'b00, 2'b00, 0, 0);
    drain();

`ifdef HAZARD_FWD_EN
    // add $3 ; add $3 ; sub $4,$3,$3 : newest producer wins
    go("s5_add1", R(5'd3, 5'd1, 5'd2), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s5_add2", R(5'd3, 5'd4, 5'd5), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s5_sub",  R(5'd4, 5'd3, 5'd3), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s5_ex",   NOP(),               0, 0, 0, 2'b10, 2'b10, 0, 0);
    drain();
    // taken branch coinciding with load-use stall
    go("s6_lw",    LW(5'd2, 5'd1),   0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s6_stl",   BEQ(5'd2, 5'd0),  1, 0, 0, 2'b00, 2'b00, 1, 0);
    go("s6_flush", BEQ(5'd2, 5'd0),  1, 0, 0, 2'b00, 2'b00, 0, 1);
    go("s6_ex",    NOP(),            0, 0, 0, 2'b01, 2'b00, 0, 0);
    drain();
    // freeze for 3 cycles with sub in EX: fw held, flush suppressed
    go("s7_add", R(5'd3, 5'd1, 5'd2), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s7_sub", R(5'd4, 5'd3, 5'd5), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s7_fz1", NOP(),               1, 1, 0, 2'b10, 2'b00, 0, 0);
    go("s7_fz2", NOP(),               0, 1, 0, 2'b10, 2'b00, 0, 0);
    go("s7_fz3", NOP(),               0, 1, 0, 2'b10, 2'b00, 0, 0);
    go("s7_rel", NOP(),               0, 0, 0, 2'b10, 2'b00, 0, 0);
    drain();
    // reset during a load-use stall discards in-flight entries
    go("s8_lw",  LW(5'd2, 5'd1),      0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s8_rst", R(5'd4, 5'd2, 5'd2), 0, 0, 1, 2'b00, 2'b00, 0, 0);
    go("s8_add", R(5'd4, 5'd2, 5'd2), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s8_ex",  NOP(),               0, 0, 0, 2'b00, 2'b00, 0, 0);
    drain();
`else
    go("s5_add1", R(5'd3, 5'd1, 5'd2), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s5_add2", R(5'd3, 5'd4, 5'd5), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s5_stl1", R(5'd4, 5'd3, 5'd3), 0, 0, 0, 2'b00, 2'b00, 1, 0);
    go("s5_stl2", R(5'd4, 5'd3, 5'd3), 0, 0, 0, 2'b00, 2'b00, 1, 0);
    go("s5_go",   R(5'd4, 5'd3, 5'd3), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s5_ex",   NOP(),               0, 0, 0, 2'b00, 2'b00, 0, 0);
    drain();
    // counter is saturated (7) from here on
    go("s6_lw",    LW(5'd2, 5'd1),  0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s6_stl1",  BEQ(5'd2, 5'd0), 1, 0, 0, 2'b00, 2'b00, 1, 0);
    go("s6_stl2",  BEQ(5'd2, 5'd0), 1, 0, 0, 2'b00, 2'b00, 1, 0);
    go("s6_flush", BEQ(5'd2, 5'd0), 1, 0, 0, 2'b00, 2'b00, 0, 1);
    go("s6_ex",    NOP(),           0, 0, 0, 2'b00, 2'b00, 0, 0);
    drain();
    // freeze over a pending dependency: stall and flush forced low
    go("s7_add",  R(5'd3, 5'd1, 5'd2), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s7_fz1",  R(5'd4, 5'd3, 5'd5), 1, 1, 0, 2'b00, 2'b00, 0, 0);
    go("s7_fz2",  R(5'd4, 5'd3, 5'd5), 0, 1, 0, 2'b00, 2'b00, 0, 0);
    go("s7_fz3",  R(5'd4, 5'd3, 5'd5), 0, 1, 0, 2'b00, 2'b00, 0, 0);
    go("s7_stl1", R(5'd4, 5'd3, 5'd5), 0, 0, 0, 2'b00, 2'b00, 1, 0);
    go("s7_stl2", R(5'd4, 5'd3, 5'd5), 0, 0, 0, 2'b00, 2'b00, 1, 0);
    go("s7_go",   R(5'd4, 5'd3, 5'd5), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s7_ex",   NOP(),               0, 0, 0, 2'b00, 2'b00, 0, 0);
    drain();
    // reset mid-stall: dependency forgotten, counter cleared
    go("s8_add",  R(5'd3, 5'd1, 5'd2), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s8_stl",  R(5'd4, 5'd3, 5'd5), 0, 0, 0, 2'b00, 2'b00, 1, 0);
    go("s8_rst",  R(5'd4, 5'd3, 5'd5), 0, 0, 1, 2'b00, 2'b00, 0, 0);
    go("s8_go",   R(5'd4, 5'd3, 5'd5), 0, 0, 0, 2'b00, 2'b00, 0, 0);
    go("s8_ex",   NOP(),               0, 0, 0, 2'b00, 2'b00, 0, 0);
    drain();
`endif

    @(posedge clk);
    @(posedge clk);
    cmp("end", "queue_left", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
